// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bundle: MEM instruction inputs, data-memory load handshake, registered writeback outputs.
// slave = the stage itself; master = whatever drives MEM and models data memory.
interface mem_wb_stage_if;
  logic        valid_me;
  logic        we_me;
  logic [4:0]  wa_me;
  logic [31:0] wd_me;
  logic        is_load_me;
  logic [2:0]  ld_type_me;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall_me;
  logic        wb_valid;
  logic        we_wb;
  logic [4:0]  wa_wb;
  logic [31:0] wd_wb;
  logic        load_err;

  modport slave (
    input  valid_me, we_me, wa_me, wd_me, is_load_me, ld_type_me, dm_ack, dm_rdata,
    output dm_req, dm_addr, stall_me, wb_valid, we_wb, wa_wb, wd_wb, load_err
  );

  modport master (
    output valid_me, we_me, wa_me, wd_me, is_load_me, ld_type_me, dm_ack, dm_rdata,
    input  dm_req, dm_addr, stall_me, wb_valid, we_wb, wa_wb, wd_wb, load_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM->WB stage: 1-cycle ALU retire, loads retire 1 cycle after dm_ack; stall_me holds EX/MEM while a load waits.
// Optional load timeout/abort under `WB_TIMEOUT_EN (TIMEOUT cycles, load_err pulse); otherwise loads wait forever.
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  mem_wb_stage_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOAD = 1'b1;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_wb_stage: TIMEOUT must be at least 1");
  end

  logic [0:0]  state;
  logic [4:0]  ld_wa;
  logic        ld_we;
  logic [2:0]  ld_type;
  logic [1:0]  ld_off;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [31:0] ld_data;
  logic        expire;

  assign bus.stall_me = (state == LOAD);

  // Little-endian lane select; offset bits were captured with the address.
  assign ld_half = ld_off[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];

  always_comb begin
    ld_byte = bus.dm_rdata[7:0];
    case (ld_off)
      2'd1:    ld_byte = bus.dm_rdata[15:8];
      2'd2:    ld_byte = bus.dm_rdata[23:16];
      2'd3:    ld_byte = bus.dm_rdata[31:24];
      default: ld_byte = bus.dm_rdata[7:0];
    endcase
    case (ld_type)
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = {16'h0000, ld_half};
      3'b011:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h000000, ld_byte};
      default: ld_data = bus.dm_rdata;
    endcase
  end

`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  // Expiry only when the data is still missing; a same-cycle ack retires normally.
  assign expire = (state == LOAD) && !bus.dm_ack && (to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt       <= '0;
      bus.load_err <= 1'b0;
    end else begin
      bus.load_err <= expire;
      if (state == IDLE)
        to_cnt <= '0;
      else if (!bus.dm_ack)
        to_cnt <= to_cnt + CW'(1);
    end
  end
`else
  assign expire       = 1'b0;
  assign bus.load_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bus.dm_req   <= 1'b0;
      bus.dm_addr  <= 32'h0;
      bus.wb_valid <= 1'b0;
      bus.we_wb    <= 1'b0;
      bus.wa_wb    <= 5'd0;
      bus.wd_wb    <= 32'h0;
      ld_wa        <= 5'd0;
      ld_we        <= 1'b0;
      ld_type      <= 3'd0;
      ld_off       <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.wb_valid <= 1'b0;
          bus.we_wb    <= 1'b0;
          if (bus.valid_me) begin
            if (bus.is_load_me) begin
              ld_wa       <= bus.wa_me;
              ld_we       <= bus.we_me;
              ld_type     <= bus.ld_type_me;
              ld_off      <= bus.wd_me[1:0];
              bus.dm_addr <= {bus.wd_me[31:2], 2'b00};
              bus.dm_req  <= 1'b1;
              state       <= LOAD;
            end else begin
              // $0 writes are dropped here since forwarding does not filter them.
              bus.wb_valid <= 1'b1;
              bus.we_wb    <= bus.we_me & (bus.wa_me != 5'd0);
              bus.wa_wb    <= bus.wa_me;
              bus.wd_wb    <= bus.wd_me;
            end
          end
        end
        LOAD: begin
          if (bus.dm_ack) begin
            bus.wd_wb    <= ld_data;
            bus.wa_wb    <= ld_wa;
            bus.we_wb    <= ld_we & (ld_wa != 5'd0);
            bus.wb_valid <= 1'b1;
            bus.dm_req   <= 1'b0;
            state        <= IDLE;
          end else if (expire) begin
            bus.wb_valid <= 1'b1;
            bus.we_wb    <= 1'b0;
            bus.dm_req   <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-to-writeback pipeline stage of the five-stage MIPS core. Accepts the instruction leaving MEM, performs the data-memory load handshake with sub-word extraction and sign/zero extension, and registers the retiring write (enable, address, data). Those registered outputs drive the register file's write port and its WB-stage forwarding inputs. A stall output holds EX/MEM while a load is outstanding.

## Interface
Parameters:
- `TIMEOUT`, 16: cycles a load may wait for `dm_ack` before abort (used only with `WB_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `valid_me`  in  1  an instruction is present in MEM this cycle.
- `we_me`  in  1  the instruction writes a GPR.
- `wa_me`  in  5  destination register.
- `wd_me`  in  32  ALU result (the effective address for loads).
- `is_load_me`  in  1  the instruction is a load.
- `ld_type_me`  in  3  load width/sign: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; other codes act as LW.
- `dm_req`  out  1  load request to data memory.
- `dm_addr`  out  32  word-aligned load address.
- `dm_ack`  in  1  data valid on `dm_rdata` this cycle.
- `dm_rdata`  in  32  little-endian read word.
- `stall_me`  out  1  hold EX/MEM and earlier stages.
- `wb_valid`  out  1  one-cycle pulse per retired instruction.
- `we_wb`  out  1  register write enable (to `we` / `we_wb`).
- `wa_wb`  out  5  write address (to `w_addr` / `wa_wb`).
- `wd_wb`  out  32  write data (to `w_data` / `wd_wb`).
- `load_err`  out  1  one-cycle pulse on load timeout.

## Operation
- FSM states: IDLE, LOAD.
- IDLE, `valid_me`=1, `is_load_me`=0: at the edge, `wb_valid`<=1, `we_wb`<=`we_me` & (`wa_me`!=0), `wa_wb`<=`wa_me`, `wd_wb`<=`wd_me`.
- IDLE, `valid_me`=1, `is_load_me`=1:
  - At the edge, latch `wa_me`, `we_me`, `ld_type_me` and `wd_me[1:0]`.
  - `dm_addr`<={`wd_me[31:2]`,2'b00}, `dm_req`<=1, `wb_valid`<=0, `we_wb`<=0; go to LOAD.
- IDLE, `valid_me`=0: `wb_valid`<=0, `we_wb`<=0. `wa_wb`/`wd_wb` hold.
- LOAD: `dm_req` stays 1 and `dm_addr` stays stable.
- LOAD, `dm_ack`=1: at the edge, `wd_wb`<=formatted data, `wa_wb`<=latched address, `we_wb`<=latched `we` & (addr!=0), `wb_valid`<=1, `dm_req`<=0; go to IDLE.
- Formatting:
  - LW: full word; `addr[1:0]` ignored (no misalignment trap).
  - LH/LHU: halfword `addr[1]` (0 = bits 15:0, 1 = bits 31:16), sign- or zero-extended.
  - LB/LBU: byte `addr[1:0]`, sign- or zero-extended.
- `stall_me` = (state==LOAD), combinational from the state register. It is therefore still high in the ack cycle; the held instruction is consumed the cycle after return to IDLE.
- `dm_ack` while in IDLE is ignored.
- Writes to register 0 are always suppressed (`we_wb`=0), because the forwarding network does not check for $0.

## Timing
- Reset (async assert): state IDLE; `dm_req`, `dm_addr`, `stall_me`, `wb_valid`, `we_wb`, `wa_wb`, `wd_wb`, `load_err` all 0.
- Reset during LOAD: `dm_req` drops immediately, no writeback, and a later `dm_ack` is ignored.
- Non-load latency: 1 cycle from MEM to WB outputs; back-to-back issue every cycle.
- Load latency: N+1 cycles, where N is the number of cycles `dm_req` is high up to and including the `dm_ack` cycle. Minimum: `dm_req` high 1 cycle, result valid 2 edges after acceptance.
- Only one load is outstanding at a time. `dm_ack` in the same cycle `dm_req` first rises counts.

## Configuration
- `WB_TIMEOUT_EN` defined:
  - A counter clears on entry to LOAD and increments each LOAD cycle without `dm_ack`.
  - When it reaches `TIMEOUT`, at that edge the block returns to IDLE with `dm_req`<=0, `wb_valid`<=1, `we_wb`<=0, and `load_err`<=1 for one cycle.
  - A `dm_ack` in the same cycle as expiry wins: normal writeback, no error.
- `WB_TIMEOUT_EN` undefined: LOAD waits indefinitely; no counter logic; `load_err` tied to 0.

## Test plan
- Reset then ALU op `wa_me`=5, `wd_me`=0x1234: one cycle later `wb_valid`=1, `we_wb`=1, `wa_wb`=5, `wd_wb`=0x1234, `stall_me`=0.
- ALU op with `wa_me`=0, `we_me`=1: `wb_valid`=1, `we_wb`=0.
- LB, addr 0x103, rdata 0x80FF_0000, ack on 3rd req cycle: `stall_me` high 3 cycles, `dm_addr`=0x100, `wd_wb`=0xFFFF_FF80; the following instruction retires 1 cycle after the load.
- LHU, addr 0x2, rdata 0xBEEF_0000: `wd_wb`=0x0000_BEEF. LH with the same inputs: `wd_wb`=0xFFFF_BEEF.
- Reset asserted mid-LOAD: `dm_req` and `stall_me` fall asynchronously, and a later `dm_ack` produces no `wb_valid`.
- With `WB_TIMEOUT_EN` and `TIMEOUT`=4, never ack: after 4 LOAD cycles `load_err` and `wb_valid` pulse, `we_wb`=0, state returns to IDLE.
